// File: rtl/calu_pkg.sv
// Shared CALU definitions: squarer state encoding, default datapath width
// and the helper that sizes the iteration counter.
package calu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqr_state_t;

  localparam int CALU_W = 16;

  // A counter of at least one bit even for degenerate W=1.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/square_seq_if.sv
// Request/result bundle of the sequential squarer, plus its state for
// checkers to bind to.
interface square_seq_if #(
  parameter int W = calu_pkg::CALU_W
);
  import calu_pkg::*;

  // Handshake: start is a request that the slave takes only while idle
  // (busy=0 and done=0); root must be valid on that edge. done pulses for one
  // cycle when square holds the new result; square stays until the next done.
  logic             start;
  logic [W-1:0]     root;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   square;
  sqr_state_t       state;

  modport master (
    output start, root,
    input  busy, done, square, state
  );

  modport slave (
    input  start, root,
    output busy, done, square, state
  );

endinterface

// File: rtl/sqr_step.sv
// One shift-add iteration of the squarer: conditionally accumulate the
// multiplicand, then shift multiplicand left and multiplier right.
module sqr_step #(
  parameter int W = 16
) (
  input  logic [2*W-1:0] acc,
  input  logic [2*W-1:0] mcand,
  input  logic [W-1:0]   mult,
  output logic [2*W-1:0] acc_nxt,
  output logic [2*W-1:0] mcand_nxt,
  output logic [W-1:0]   mult_nxt,
  output logic           zero
);

  // acc never exceeds root*root, so the 2W-bit add cannot wrap.
  assign acc_nxt   = mult[0] ? (acc + mcand) : acc;
  assign mcand_nxt = mcand << 1;
  assign mult_nxt  = mult >> 1;
  assign zero      = (mult_nxt == '0);

endmodule

// File: rtl/square_seq.sv
// Sequential shift-add squarer: W-bit root in, exact 2W-bit square out.
// Optional SQR_EARLY_EXIT_EN ends CALC as soon as the multiplier runs out of set bits.
module square_seq
  import calu_pkg::*;
#(
  parameter int W = CALU_W
) (
  input  logic        clk,
  input  logic        rst,
  square_seq_if.slave bus
);

  localparam int CW = cnt_w(W);

  sqr_state_t       state;
  logic [2*W-1:0]   acc;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mult;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [2*W-1:0]   square_q;

  logic [2*W-1:0]   acc_nxt;
  logic [2*W-1:0]   mcand_nxt;
  logic [W-1:0]     mult_nxt;
  logic             step_zero;
  logic             last_iter;

  sqr_step #(.W(W)) u_step (
    .acc       (acc),
    .mcand     (mcand),
    .mult      (mult),
    .acc_nxt   (acc_nxt),
    .mcand_nxt (mcand_nxt),
    .mult_nxt  (mult_nxt),
    .zero      (step_zero)
  );

`ifdef SQR_EARLY_EXIT_EN
  // Once no set bits remain in the multiplier, acc already holds the result.
  assign last_iter = (cnt == CW'(W - 1)) || step_zero;
`else
  logic unused_zero;
  assign unused_zero = step_zero;
  assign last_iter   = (cnt == CW'(W - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mult     <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      square_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= {{W{1'b0}}, bus.root};
            mult   <= bus.root;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_nxt;
          mcand <= mcand_nxt;
          mult  <= mult_nxt;
          cnt   <= cnt + CW'(1);
          // The final iteration's add goes straight into the result.
          if (last_iter) begin
            square_q <= acc_nxt;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.square = square_q;
  assign bus.state  = state;

endmodule

// File: tb/tb_square_seq.sv
// Bench for square_seq: cycle-level behavioural model, per-cycle compare,
// a result scoreboard and literal spot checks.
module tb_square_seq;
  import calu_pkg::*;

  localparam int W = 16;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;

  square_seq_if #(.W(W)) bus ();

  square_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int lat(input logic [W-1:0] r);
`ifdef SQR_EARLY_EXIT_EN
    int p = 1;
    for (int i = 0; i < W; i++) if (r[i]) p = i + 1;
    return p;
`else
    return W;
`endif
  endfunction

  function automatic logic [2*W-1:0] sq(input logic [W-1:0] r);
    logic [2*W-1:0] x;
    x = {{W{1'b0}}, r};
    return x * x;
  endfunction

  int             m_left = 0;
  bit             m_done = 0;
  int             m_lat  = 0;
  logic [2*W-1:0] m_pend = '0;
  logic [2*W-1:0] m_sq   = '0;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_sq   = '0;
      exp_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1;
        m_sq   = m_pend;
      end
    end else if (bus.start) begin
      m_lat  = lat(bus.root);
      m_left = m_lat;
      m_pend = sq(bus.root);
      exp_q.push_back(m_pend);
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  int busy_run = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      if (rst) begin
        busy_run = 0;
      end else begin
        check("busy", 64'(bus.busy), 64'(m_left > 0));
        check("done", 64'(bus.done), 64'(m_done));
        check("square", 64'(bus.square), 64'(m_sq));
        check("state", 64'(bus.state),
              64'(m_done ? DONE : (m_left > 0 ? CALC : IDLE)));
        if (bus.busy) busy_run++;
        if (bus.done) begin
          check("busy_cycles", 64'(busy_run), 64'(m_lat));
          busy_run = 0;
          if (exp_q.size() == 0) check("sb_nonempty", 64'(0), 64'(1));
          else check("sb_square", 64'(bus.square), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] r);
    @(negedge clk);
    bus.start = 1'b1;
    bus.root  = r;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0]   edge_roots [4];
  logic [2*W-1:0] edge_sq    [4];
  logic [W-1:0]   r;

  initial begin
    edge_roots = '{16'd0, 16'd1, 16'd255, 16'd65535};
    edge_sq    = '{32'd0, 32'd1, 32'd65025, 32'd4294836225};
    rst = 1'b1;
    bus.start = 1'b0;
    bus.root  = '0;
    repeat (3) @(negedge clk);
    check("reset_square", 64'(bus.square), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;
    chk_en = 1;

    // Basic operation
    start_op(16'd12);
    wait_done("op12");
    check("op12_square", 64'(bus.square), 64'd144);
    check("model_pin_144", 64'(sq(16'd12)), 64'd144);

    // Boundary operands back to back
    for (int i = 0; i < 4; i++) begin
      start_op(edge_roots[i]);
      wait_done("edge");
      check("edge_square", 64'(bus.square), 64'(edge_sq[i]));
    end
    check("model_pin_65535", 64'(sq(16'hffff)), 64'd4294836225);
`ifdef SQR_EARLY_EXIT_EN
    check("lat_pin_4", 64'(lat(16'd4)), 64'd3);
`endif

    // Start ignored in CALC and DONE; held start accepted on first IDLE edge
    start_op(16'd7);
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'b1;
      bus.root  = 16'd3;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_done("ign");
    check("ign_square", 64'(bus.square), 64'd49);
    bus.start = 1'b1;
    bus.root  = 16'd5;
    for (int i = 0; i < 10 && !bus.busy; i++) @(negedge clk);
    bus.start = 1'b0;
    wait_done("held");
    check("held_square", 64'(bus.square), 64'd25);

    // Reset mid-operation
    start_op(16'd100);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_square", 64'(bus.square), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_op(16'd100);
    wait_done("op100");
    check("op100_square", 64'(bus.square), 64'd10000);

    // Random roots, root and start scrambled while busy
    for (int n = 0; n < 20; n++) begin
      r = W'($urandom_range(0, 65535));
      start_op(r);
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (bus.done) break;
        bus.root  = W'($urandom);
        bus.start = ($urandom_range(0, 3) == 0);
      end
      bus.start = 1'b0;
      check("rand_square", 64'(bus.square), 64'(sq(r)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (25) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL global_timeout: got running expected finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
